bicubic_win_fetch: RTL and testbench
====================================

Name: bicubic_win_fetch

Overview:
- Source-window fetch stage inside Bicubic, directly upstream of the bicubic interpolation datapath.
- Takes an integer source coordinate (window-relative) and reads the 4x4 neighbourhood from ImgROM, a 100-pixel-wide image with 1-cycle read latency.
- Clamps neighbourhood coordinates to the configured SWxSH source window.
- Keeps a sliding column cache so horizontally adjacent requests cost 4 ROM reads instead of 16.
- Presents the 16-pixel window to the interpolator over a valid/ready handshake.

Parameters:
- IMG_W, 100, image row pitch in pixels.
- ROM_AW, 14, ImgROM address width.
- PIX_W, 8, pixel width in bits.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset, asynchronous, active-low.
- cfg_load  in  1  pulse; latch H0/V0/SW/SH.
- H0  in  7  source window x origin.
- V0  in  7  source window y origin.
- SW  in  5  source window width.
- SH  in  5  source window height.
- req_valid  in  1  fetch request valid.
- req_ready  out  1  block can accept a request.
- req_x  in  5  integer source x, window-relative.
- req_y  in  5  integer source y, window-relative.
- rom_ren  out  1  ImgROM read enable.
- rom_addr  out  ROM_AW  ImgROM address.
- rom_q  in  PIX_W  ImgROM data, valid the cycle after rom_ren.
- win_valid  out  1  window output valid.
- win_ready  in  1  interpolator accepts the window.
- win_data  out  16*PIX_W  pixel(r,c) at bits [(r*4+c)*PIX_W +: PIX_W]; r = row 0..3, c = column 0..3.

Behaviour:
- Reset (RST=0, async): state IDLE; cfg_seen=0; cache_valid=0.
  - Outputs: req_ready=0, rom_ren=0, rom_addr=0, win_valid=0, win_data=0.
  - Reset during a fetch aborts it immediately: rom_ren drops in the same cycle, no window is produced.
- cfg_load: honoured only in IDLE; ignored in other states.
  - Latches H0, V0, SW, SH.
  - Sets cfg_seen=1 and clears cache_valid.
- req_ready = (state==IDLE) && cfg_seen. Registered, so it is 0 on the first cycle after reset release.
- Neighbourhood coordinates:
  - cx(c) = clamp(req_x + c - 1, 0, SW-1) for c = 0..3.
  - cy(r) = clamp(req_y + r - 1, 0, SH-1) for r = 0..3.
  - Computed at 7-bit signed width, so -1 clamps to 0 and out-of-range req_x/req_y clamp to SW-1/SH-1.
- Address = (V0+cy)*IMG_W + H0 + cx, computed as 14-bit unsigned using shift-add (y*100 = y<<6 + y<<5 + y<<2).
- The caller guarantees H0+SW <= 100 and V0+SH <= 100; behaviour outside that is undefined.
- States: IDLE, FETCH, HOLD.
  - IDLE, request accepted: choose the mode below and go to FETCH, or straight to HOLD on a hit.
  - FETCH: issue one address per cycle with rom_ren=1. Capture rom_q one cycle after each read into the addressed slot. Go to HOLD the cycle after the last capture.
  - HOLD: win_valid=1 and win_data stable until win_ready=1; on that cycle go to IDLE.
- Fetch modes, decided on acceptance against last_x/last_y, with cache_valid=1 required for the first two:
  - HIT: req_x==last_x and req_y==last_y. 0 reads; win_valid is high the cycle after acceptance.
  - SHIFT: req_y==last_y and req_x==last_x+1. Columns 1..3 move to 0..2, then 4 reads for column 3 in rows 0..3. win_valid is high 6 cycles after acceptance.
  - FULL: any other request. 16 reads, column-major (c0 r0..r3, then c1, ...). win_valid is high 18 cycles after acceptance.
- At the right edge SHIFT still re-reads the clamped column; no special case.
- After a window is delivered: last_x/last_y are updated and cache_valid=1.
- win_ready while win_valid=0 is ignored.
- No request is accepted on the same cycle as the window handoff.

Decomposition:
- bicubic_pkg holds:
  - IMG_W, ROM_AW, PIX_W.
  - The typedefs pix_t, win_t (4x4 pix_t) and fetch_mode_e {HIT, SHIFT, FULL}.
  - The state enum {IDLE, FETCH, HOLD}.
  - The function clamp_coord.
- Sub-module bicubic_win_addr: combinational clamp plus address generation, with inputs (cfg, req_x, req_y, r, c) and output rom_addr. It is reused later by the write-back address logic.

Test Plan:
- cfg H0=10, V0=20, SW=8, SH=8; req (3,3) -> reads 2212, 2312, 2412, 2512, 2213 … 2515 (16 reads); win_valid at cycle 18; win_data equals the ROM contents.
- Then req (4,3) -> exactly 4 reads 2216, 2316, 2416, 2516; win_valid at cycle 6; new columns 0..2 equal previous columns 1..3.
- Repeat req (4,3) -> 0 reads; win_valid the cycle after acceptance; data unchanged. A cfg_load then the same req -> FULL, 16 reads.
- Clamping:
  - H0=V0=0, SW=SH=4, req (0,0) -> cx = 0,0,1,2; column 0 duplicates column 1; row 0 duplicates row 1.
  - req (3,3) -> cx = 2,3,3,3.
- Backpressure: win_ready held low 10 cycles -> win_data stable, req_ready=0, rom_ren=0; win_ready=1 -> IDLE, req_ready=1 next cycle.
- RST low at fetch cycle 7 -> rom_ren=0 and win_valid=0 immediately; after release, req_ready stays 0 until cfg_load; the next request does a FULL fetch.

Source files
------------

// File: rtl/bicubic_pkg.sv
// Shared types, constants and the coordinate clamp used by the bicubic
// source-window fetch stage and its address generator.
package bicubic_pkg;

  localparam int IMG_W  = 100;
  localparam int ROM_AW = 14;
  localparam int PIX_W  = 8;

  typedef logic [PIX_W-1:0] pix_t;

  // win[r][c]; packed so that pixel(r,c) sits at bits [(r*4+c)*PIX_W +: PIX_W]
  typedef pix_t [3:0][3:0] win_t;

  typedef enum logic [1:0] {
    HIT   = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } fetch_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  typedef struct packed {
    logic [6:0] h0;
    logic [6:0] v0;
    logic [4:0] sw;
    logic [4:0] sh;
  } cfg_t;

  // clamp(base + off - 1, 0, lim - 1), evaluated at 7-bit signed width so the
  // -1 tap of coordinate 0 lands on 0 and oversize coordinates land on lim-1.
  function automatic logic [4:0] clamp_coord(input logic [4:0] base,
                                             input logic [1:0] off,
                                             input logic [4:0] lim);
    logic signed [6:0] v;
    logic signed [6:0] hi;
    v  = $signed({2'b00, base}) + $signed({5'b00000, off}) - 7'sd1;
    hi = $signed({2'b00, lim}) - 7'sd1;
    if (v < 7'sd0) begin
      return 5'd0;
    end else if (v > hi) begin
      return hi[4:0];
    end else begin
      return v[4:0];
    end
  endfunction

endpackage

// File: rtl/bicubic_win_addr.sv
// Clamp one neighbourhood tap (r,c) into the source window and turn it into
// an ImgROM address. Pure combinational; also reused by write-back logic.
module bicubic_win_addr
  import bicubic_pkg::*;
(
  input  cfg_t              cfg,
  input  logic [4:0]        req_x,
  input  logic [4:0]        req_y,
  input  logic [1:0]        r,
  input  logic [1:0]        c,
  output logic [ROM_AW-1:0] rom_addr
);

  logic [4:0]        cx;
  logic [4:0]        cy;
  logic [ROM_AW-1:0] row;
  logic [ROM_AW-1:0] row_base;

  // row * 100 built as row*64 + row*32 + row*4, then add the column offset
  always_comb begin
    cx       = clamp_coord(req_x, c, cfg.sw);
    cy       = clamp_coord(req_y, r, cfg.sh);
    row      = ROM_AW'(cfg.v0) + ROM_AW'(cy);
    row_base = (row << 6) + (row << 5) + (row << 2);
    rom_addr = row_base + ROM_AW'(cfg.h0) + ROM_AW'(cx);
  end

endmodule

// File: rtl/bicubic_win_fetch.sv
// Source-window fetch stage: reads the 4x4 neighbourhood of a request from
// ImgROM (1-cycle latency), reusing a sliding column cache, and hands the
// window to the interpolator.
//
// Handshakes: a transfer happens on a rising CLK edge where both valid and
// ready are high; valid never depends on ready, and once win_valid is raised
// win_data holds steady until the transfer. req_ready is a function of
// registers only. A cfg_load coinciding with an accepted request still
// accepts the request, but forces a FULL fetch so the cache only ever holds
// data read under the active configuration.
module bicubic_win_fetch
  import bicubic_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                cfg_load,
  input  logic [6:0]          H0,
  input  logic [6:0]          V0,
  input  logic [4:0]          SW,
  input  logic [4:0]          SH,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [4:0]          req_x,
  input  logic [4:0]          req_y,
  output logic                rom_ren,
  output logic [ROM_AW-1:0]   rom_addr,
  input  logic [PIX_W-1:0]    rom_q,
  output logic                win_valid,
  input  logic                win_ready,
  output logic [16*PIX_W-1:0] win_data,
  output logic [1:0]          dbg_state
);

  state_e            state_q;
  state_e            state_d;
  cfg_t              cfg_q;
  logic              cfg_seen_q;
  logic              cache_valid_q;
  logic [4:0]        last_x_q;
  logic [4:0]        last_y_q;
  logic [4:0]        cur_x_q;
  logic [4:0]        cur_y_q;
  fetch_mode_e       mode_q;
  fetch_mode_e       mode_sel;
  logic [4:0]        rd_cnt_q;
  logic [4:0]        n_reads;
  logic              rd_pend_q;
  logic [1:0]        cap_r_q;
  logic [1:0]        cap_c_q;
  logic [1:0]        issue_r;
  logic [1:0]        issue_c;
  logic              accept;
  logic              issuing;
  logic              cfg_take;
  logic              handoff;
  logic [ROM_AW-1:0] addr_w;
  win_t              win_q;

  // Handshake qualifiers and the read sequencer's current tap
  always_comb begin
    accept   = req_valid && (state_q == IDLE) && cfg_seen_q;
    cfg_take = cfg_load && (state_q == IDLE);
    handoff  = (state_q == HOLD) && win_ready;
    n_reads  = (mode_q == SHIFT) ? 5'd4 : 5'd16;
    issuing  = (state_q == FETCH) && (rd_cnt_q < n_reads);
    issue_r  = rd_cnt_q[1:0];
    issue_c  = (mode_q == SHIFT) ? 2'd3 : rd_cnt_q[3:2];
  end

  // Classify an incoming request against the cached window
  always_comb begin
    mode_sel = FULL;
    if (cache_valid_q && !cfg_load && (req_y == last_y_q)) begin
      if (req_x == last_x_q) begin
        mode_sel = HIT;
      end else if ({1'b0, req_x} == ({1'b0, last_x_q} + 6'd1)) begin
        mode_sel = SHIFT;
      end
    end
  end

  bicubic_win_addr u_addr (
    .cfg      (cfg_q),
    .req_x    (cur_x_q),
    .req_y    (cur_y_q),
    .r        (issue_r),
    .c        (issue_c),
    .rom_addr (addr_w)
  );

  // FSM state register
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: HOLD follows the cycle in which the last read is captured
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = (mode_sel == HIT) ? HOLD : FETCH;
      FETCH:   if (!issuing && rd_pend_q) state_d = HOLD;
      HOLD:    if (win_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; the address bus idles at zero when no read is issued
  always_comb begin
    req_ready = (state_q == IDLE) && cfg_seen_q;
    rom_ren   = issuing;
    rom_addr  = issuing ? addr_w : '0;
    win_valid = (state_q == HOLD);
    dbg_state = state_q;
  end

  assign win_data = win_q;

  // Configuration, request latch and cache bookkeeping
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cfg_q         <= '0;
      cfg_seen_q    <= 1'b0;
      cache_valid_q <= 1'b0;
      last_x_q      <= '0;
      last_y_q      <= '0;
      cur_x_q       <= '0;
      cur_y_q       <= '0;
      mode_q        <= FULL;
    end else begin
      if (cfg_take) begin
        cfg_q         <= '{h0: H0, v0: V0, sw: SW, sh: SH};
        cfg_seen_q    <= 1'b1;
        cache_valid_q <= 1'b0;
      end
      if (accept) begin
        cur_x_q <= req_x;
        cur_y_q <= req_y;
        mode_q  <= mode_sel;
      end
      if (handoff) begin
        last_x_q      <= cur_x_q;
        last_y_q      <= cur_y_q;
        cache_valid_q <= 1'b1;
      end
    end
  end

  // Read sequencer: count issued reads and remember where each lands
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rd_cnt_q  <= '0;
      rd_pend_q <= 1'b0;
      cap_r_q   <= '0;
      cap_c_q   <= '0;
    end else begin
      if (accept) begin
        rd_cnt_q <= '0;
      end else if (issuing) begin
        rd_cnt_q <= rd_cnt_q + 5'd1;
      end
      rd_pend_q <= issuing;
      cap_r_q   <= issue_r;
      cap_c_q   <= issue_c;
    end
  end

  // Window cache: slide left on SHIFT, capture ROM data one cycle after a read
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      win_q <= '0;
    end else begin
      if (accept && (mode_sel == SHIFT)) begin
        for (int r = 0; r < 4; r++) begin
          for (int c = 0; c < 3; c++) begin
            win_q[r][c] <= win_q[r][c+1];
          end
        end
      end
      if (rd_pend_q) begin
        win_q[cap_r_q][cap_c_q] <= rom_q;
      end
    end
  end

endmodule

// File: tb/tb_bicubic_win_fetch.sv
// Bench for bicubic_win_fetch: behavioural ImgROM, per-scenario tasks and an
// address/window scoreboard built from an independent coordinate model.
module tb_bicubic_win_fetch;
  import bicubic_pkg::*;

  localparam int WW = 16 * PIX_W;

  logic              CLK = 1'b0;
  logic              RST = 1'b1;
  logic              cfg_load = 1'b0;
  logic [6:0]        H0 = '0;
  logic [6:0]        V0 = '0;
  logic [4:0]        SW = '0;
  logic [4:0]        SH = '0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [4:0]        req_x = '0;
  logic [4:0]        req_y = '0;
  logic              rom_ren;
  logic [ROM_AW-1:0] rom_addr;
  logic [PIX_W-1:0]  rom_q = '0;
  logic              win_valid;
  logic              win_ready = 1'b1;
  logic [WW-1:0]     win_data;
  logic [1:0]        dbg_state;

  // clock / ROM model
  always #5 CLK = ~CLK;

  logic [PIX_W-1:0] rom_mem [0:(1<<ROM_AW)-1];
  always @(posedge CLK) if (rom_ren) rom_q <= rom_mem[rom_addr];

  bicubic_win_fetch dut (
    .CLK(CLK), .RST(RST), .cfg_load(cfg_load), .H0(H0), .V0(V0), .SW(SW), .SH(SH),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .rom_ren(rom_ren), .rom_addr(rom_addr), .rom_q(rom_q),
    .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
    .dbg_state(dbg_state)
  );

  // scoreboard state
  logic [ROM_AW-1:0] exp_q[$];
  logic [ROM_AW-1:0] got_q[$];
  logic [WW-1:0]     exp_win_q[$];
  int n_checks = 0;
  int n_fail   = 0;
  int m_h0, m_v0, m_sw, m_sh;
  logic [WW-1:0] last_win;

  function automatic int clampi(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic int model_addr(input int x, input int y, input int r, input int c);
    return (m_v0 + clampi(y + r - 1, m_sh - 1)) * IMG_W + m_h0 + clampi(x + c - 1, m_sw - 1);
  endfunction

  function automatic logic [PIX_W-1:0] get_pix(input logic [WW-1:0] w, input int r, input int c);
    return w[(r*4+c)*PIX_W +: PIX_W];
  endfunction

  // mode: 0 = hit, 1 = shift, 2 = full
  task automatic push_exp(input int x, input int y, input int mode);
    logic [WW-1:0] w;
    w = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        w[(r*4+c)*PIX_W +: PIX_W] = rom_mem[model_addr(x, y, r, c)];
    exp_win_q.push_back(w);
    if (mode == 2) begin
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++)
          exp_q.push_back(ROM_AW'(model_addr(x, y, r, c)));
    end else if (mode == 1) begin
      for (int r = 0; r < 4; r++)
        exp_q.push_back(ROM_AW'(model_addr(x, y, r, 3)));
    end
  endtask

  // driver: one cfg_load pulse, mirrored into the model
  task automatic do_cfg(input int h0, input int v0, input int sw, input int sh);
    @(posedge CLK); #1;
    cfg_load = 1'b1; H0 = 7'(h0); V0 = 7'(v0); SW = 5'(sw); SH = 5'(sh);
    @(posedge CLK); #1;
    cfg_load = 1'b0;
    m_h0 = h0; m_v0 = v0; m_sw = sw; m_sh = sh;
  endtask

  // driver: issue one request, log reads, return latency and first window seen
  task automatic drive_req(input int x, input int y, output int lat, output logic [WW-1:0] win);
    logic ok;
    ok  = 1'b0;
    lat = 0;
    win = '0;
    got_q.delete();
    @(posedge CLK); #1;
    req_valid = 1'b1; req_x = 5'(x); req_y = 5'(y);
    for (int g = 0; g < 50; g++) begin
      @(negedge CLK);
      if (req_ready) begin ok = 1'b1; break; end
    end
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL req_accept: req_ready got 0 want 1 within 50 cycles"); end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge CLK);
      if (rom_ren) got_q.push_back(rom_addr);
      if (win_valid) begin lat = k; win = win_data; break; end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge CLK);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got %b want 0", req_ready); end
    n_checks++; if (rom_ren !== 1'b0) begin n_fail++; $display("FAIL rst_rom_ren: got %b want 0", rom_ren); end
    n_checks++; if (rom_addr !== '0) begin n_fail++; $display("FAIL rst_rom_addr: got %0d want 0", rom_addr); end
    n_checks++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL rst_win_valid: got %b want 0", win_valid); end
    n_checks++; if (win_data !== '0) begin n_fail++; $display("FAIL rst_win_data: got %h want 0", win_data); end
    n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d want 0", dbg_state); end
    @(posedge CLK); #1;
    RST = 1'b1;
    @(negedge CLK);
    n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL post_rst_req_ready: got %b want 0", req_ready); end
  endtask

  task automatic test_full_fetch();
    int lat; logic [WW-1:0] win; logic [ROM_AW-1:0] e, a;
    do_cfg(10, 20, 8, 8);
    push_exp(3, 3, 2);
    drive_req(3, 3, lat, win);
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL full_latency: got %0d want 18", lat); end
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL full_nreads: got %0d want %0d", got_q.size(), exp_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = (got_q.size() > 0) ? got_q.pop_front() : '1;
      n_checks++; if (a !== e) begin n_fail++; $display("FAIL full_addr: got %0d want %0d", a, e); end
    end
    n_checks++; if (win !== exp_win_q[0]) begin n_fail++; $display("FAIL full_window: got %h want %h", win, exp_win_q[0]); end
    void'(exp_win_q.pop_front());
    last_win = win;
  endtask

  task automatic test_shift();
    int lat; logic [WW-1:0] win; logic [ROM_AW-1:0] e, a;
    push_exp(4, 3, 1);
    drive_req(4, 3, lat, win);
    n_checks++; if (lat !== 6) begin n_fail++; $display("FAIL shift_latency: got %0d want 6", lat); end
    n_checks++; if (got_q.size() !== 4) begin n_fail++; $display("FAIL shift_nreads: got %0d want 4", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = (got_q.size() > 0) ? got_q.pop_front() : '1;
      n_checks++; if (a !== e) begin n_fail++; $display("FAIL shift_addr: got %0d want %0d", a, e); end
    end
    n_checks++; if (win !== exp_win_q[0]) begin n_fail++; $display("FAIL shift_window: got %h want %h", win, exp_win_q[0]); end
    void'(exp_win_q.pop_front());
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++) begin
        n_checks++;
        if (get_pix(win, r, c) !== get_pix(last_win, r, c + 1)) begin
          n_fail++; $display("FAIL shift_slide r%0d c%0d: got %h want %h", r, c, get_pix(win, r, c), get_pix(last_win, r, c + 1));
        end
      end
    last_win = win;
  endtask

  task automatic test_hit();
    int lat; logic [WW-1:0] win; logic [ROM_AW-1:0] e, a;
    push_exp(4, 3, 0);
    drive_req(4, 3, lat, win);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL hit_latency: got %0d want 1", lat); end
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL hit_nreads: got %0d want 0", got_q.size()); end
    n_checks++; if (win !== exp_win_q[0]) begin n_fail++; $display("FAIL hit_window: got %h want %h", win, exp_win_q[0]); end
    void'(exp_win_q.pop_front());
    n_checks++; if (win !== last_win) begin n_fail++; $display("FAIL hit_unchanged: got %h want %h", win, last_win); end
    // reloading the configuration invalidates the cache
    do_cfg(10, 20, 8, 8);
    push_exp(4, 3, 2);
    drive_req(4, 3, lat, win);
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL recfg_latency: got %0d want 18", lat); end
    n_checks++; if (got_q.size() !== 16) begin n_fail++; $display("FAIL recfg_nreads: got %0d want 16", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = (got_q.size() > 0) ? got_q.pop_front() : '1;
      n_checks++; if (a !== e) begin n_fail++; $display("FAIL recfg_addr: got %0d want %0d", a, e); end
    end
    n_checks++; if (win !== exp_win_q[0]) begin n_fail++; $display("FAIL recfg_window: got %h want %h", win, exp_win_q[0]); end
    void'(exp_win_q.pop_front());
  endtask

  task automatic test_clamp();
    int lat; logic [WW-1:0] win; logic [ROM_AW-1:0] e, a;
    int xs[3]; int ys[3]; int ms[3]; int ls[3];
    xs = '{0, 3, 4}; ys = '{0, 3, 3}; ms = '{2, 2, 1}; ls = '{18, 18, 6};
    do_cfg(0, 0, 4, 4);
    for (int t = 0; t < 3; t++) begin
      push_exp(xs[t], ys[t], ms[t]);
      drive_req(xs[t], ys[t], lat, win);
      n_checks++; if (lat !== ls[t]) begin n_fail++; $display("FAIL clamp_latency t%0d: got %0d want %0d", t, lat, ls[t]); end
      n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL clamp_nreads t%0d: got %0d want %0d", t, got_q.size(), exp_q.size()); end
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front(); a = (got_q.size() > 0) ? got_q.pop_front() : '1;
        n_checks++; if (a !== e) begin n_fail++; $display("FAIL clamp_addr t%0d: got %0d want %0d", t, a, e); end
      end
      n_checks++; if (win !== exp_win_q[0]) begin n_fail++; $display("FAIL clamp_window t%0d: got %h want %h", t, win, exp_win_q[0]); end
      void'(exp_win_q.pop_front());
      if (t == 0) begin
        for (int i = 0; i < 4; i++) begin
          n_checks++; if (get_pix(win, i, 0) !== get_pix(win, i, 1)) begin n_fail++; $display("FAIL clamp_col0 r%0d: got %h want %h", i, get_pix(win, i, 0), get_pix(win, i, 1)); end
          n_checks++; if (get_pix(win, 0, i) !== get_pix(win, 1, i)) begin n_fail++; $display("FAIL clamp_row0 c%0d: got %h want %h", i, get_pix(win, 0, i), get_pix(win, 1, i)); end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [WW-1:0] win;
    do_cfg(10, 20, 8, 8);
    win_ready = 1'b0;
    push_exp(1, 1, 2);
    drive_req(1, 1, lat, win);
    exp_q.delete();
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL bp_latency: got %0d want 18", lat); end
    n_checks++; if (win !== exp_win_q[0]) begin n_fail++; $display("FAIL bp_window: got %h want %h", win, exp_win_q[0]); end
    void'(exp_win_q.pop_front());
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK);
      n_checks++;
      if (win_data !== win || req_ready !== 1'b0 || rom_ren !== 1'b0 || win_valid !== 1'b1 || dbg_state !== 2'd2) begin
        n_fail++;
        $display("FAIL bp_hold k%0d: got data %h rdy %b ren %b vld %b st %0d want data %h rdy 0 ren 0 vld 1 st 2",
                 k, win_data, req_ready, rom_ren, win_valid, dbg_state, win);
      end
    end
    @(posedge CLK); #1;
    win_ready = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    n_checks++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release_valid: got %b want 0", win_valid); end
    n_checks++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_reset_abort();
    int lat; logic [WW-1:0] win; logic [ROM_AW-1:0] e, a; logic ok; logic saw_valid;
    ok = 1'b0;
    @(posedge CLK); #1;
    req_valid = 1'b1; req_x = 5'd2; req_y = 5'd2;
    for (int g = 0; g < 50; g++) begin
      @(negedge CLK);
      if (req_ready) begin ok = 1'b1; break; end
    end
    n_checks++; if (!ok) begin n_fail++; $display("FAIL abort_accept: req_ready got 0 want 1 within 50 cycles"); end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge CLK);
    #2;
    n_checks++; if (rom_ren !== 1'b1) begin n_fail++; $display("FAIL abort_pre_ren: got %b want 1", rom_ren); end
    RST = 1'b0;
    #1;
    n_checks++; if (rom_ren !== 1'b0) begin n_fail++; $display("FAIL abort_ren: got %b want 0", rom_ren); end
    n_checks++; if (rom_addr !== '0) begin n_fail++; $display("FAIL abort_addr: got %0d want 0", rom_addr); end
    n_checks++; if (win_valid !== 1'b0) begin n_fail++; $display("FAIL abort_valid: got %b want 0", win_valid); end
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    saw_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge CLK);
      n_checks++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL abort_no_cfg_ready k%0d: got %b want 0", k, req_ready); end
      if (win_valid) saw_valid = 1'b1;
    end
    n_checks++; if (saw_valid !== 1'b0) begin n_fail++; $display("FAIL abort_no_window: got %b want 0", saw_valid); end
    do_cfg(10, 20, 8, 8);
    push_exp(2, 2, 2);
    drive_req(2, 2, lat, win);
    n_checks++; if (lat !== 18) begin n_fail++; $display("FAIL abort_refetch_latency: got %0d want 18", lat); end
    n_checks++; if (got_q.size() !== 16) begin n_fail++; $display("FAIL abort_refetch_nreads: got %0d want 16", got_q.size()); end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); a = (got_q.size() > 0) ? got_q.pop_front() : '1;
      n_checks++; if (a !== e) begin n_fail++; $display("FAIL abort_refetch_addr: got %0d want %0d", a, e); end
    end
    n_checks++; if (win !== exp_win_q[0]) begin n_fail++; $display("FAIL abort_refetch_window: got %h want %h", win, exp_win_q[0]); end
    void'(exp_win_q.pop_front());
  endtask

  initial begin
    for (int i = 0; i < (1 << ROM_AW); i++) rom_mem[i] = PIX_W'($urandom_range(0, 255));
    #1;
    RST = 1'b0;
    test_reset();
    test_full_fetch();
    test_shift();
    test_hit();
    test_clamp();
    test_backpressure();
    test_reset_abort();
    @(posedge CLK);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
